pwm_gen: RTL
============

Name: pwm_gen

Overview:
- Dual-channel sign/magnitude PWM transmitter. Converts a 14-bit signed duty command into pulses on CH_A (positive duty) or CH_B (negative duty).
- Fixed period of 2^PERIOD_W clocks.
- Output is the stimulus that pwm_monitor decodes. pwm_gen output fed into pwm_monitor must reproduce the commanded duty with duty_valid asserted.
- Sits between the control loop and the motor driver pins.

Parameters:
PERIOD_W, 13, counter width; period = 2^PERIOD_W clocks; duty width DUTY_W = PERIOD_W+1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high (fixed: one clock, async active-high reset)
en  in  1  generator enable
duty  in  DUTY_W  signed two's-complement duty command
duty_wr  in  1  1-cycle strobe; capture duty into shadow register
CH_A  out  1  PWM output, positive direction (registered)
CH_B  out  1  PWM output, negative direction (registered)
prd_start  out  1  1-cycle pulse on the first clock of each period (registered)
duty_pend  out  1  shadow holds a command not yet applied

Behaviour:
- Reset (async, rst=1):
  - cnt=0, active mag=0, active sgn=0, shadow=0, last_sgn=0, state=IDLE.
  - CH_A, CH_B, prd_start and duty_pend are all 0.
- Magnitude conversion:
  - sgn = duty[MSB].
  - mag = sgn ? -duty : duty, in PERIOD_W bits.
  - duty = 0x2000 (-8192) saturates to mag = 8191.
  - Max mag is therefore 8191, so every non-zero period has a falling edge.
  - duty = 0 gives sgn = 0, mag = 0.
- Shadow register:
  - duty_wr loads shadow and sets duty_pend. The last write before a boundary wins.
  - The boundary is the edge where cnt wraps 2^PERIOD_W-1 -> 0 with en=1.
  - At the boundary, active <= shadow and duty_pend clears.
  - If duty_wr coincides with the boundary edge, the incoming duty bypasses the shadow straight into active, and duty_pend = 0.
- Counter: cnt increments every clock in RUN and DEAD, and wraps naturally. prd_start = 1 on the clock where cnt == 0.
- Outputs:
  - Outputs are registered from the next-count comparison.
  - In RUN: CH_A = ~sgn & (cnt < mag); CH_B = sgn & (cnt < mag).
  - The active channel is high for exactly mag consecutive clocks starting at cnt == 0, then low for the rest of the period.
  - CH_A & CH_B is never 1; the bench asserts this every cycle.
- FSM:
  - IDLE:
    - Outputs low, cnt held at 0.
    - On en=1: take the shadow into active if pending, set cnt = 0, pulse prd_start, then go to RUN (or DEAD by the reversal rule).
  - RUN:
    - Drives as above.
    - At each boundary, load new active. If new mag != 0, last_sgn was from a non-zero duty, and the new sgn != last_sgn, go to DEAD; otherwise stay in RUN.
    - last_sgn updates only on non-zero mag.
  - DEAD:
    - Exactly one full period with both outputs low (direction-reversal dead time).
    - At its end, return to RUN with the held active value.
    - A duty_wr during DEAD is deferred to the following boundary.
    - One all-low period (8192 clocks) is shorter than the monitor's 8193-clock timeout, so no spurious zero report is produced.
  - Any state with en=0: at the next edge outputs go low, cnt = 0, state = IDLE. Active, shadow, last_sgn and duty_pend are retained.
- Reset mid-pulse: outputs drop asynchronously, and everything returns to reset values.

Decomposition:
- Package pwm_pkg holds:
  - PERIOD_W, DUTY_W, MAG_MAX = 2^PERIOD_W-1;
  - the state enum {IDLE, RUN, DEAD}, 2-bit.
- One combinational sub-module, pwm_mag_conv (duty -> sgn, saturated mag), reused by the shadow bypass path and available to other blocks.
- Counter, shadow and FSM stay in pwm_gen.

Test Plan:
1. rst, en=1, duty_wr with duty=0x0400 -> from the next boundary, CH_A high for 1024 clocks every 8192, CH_B=0. A connected pwm_monitor gives duty=0x0400 with duty_valid=1 on the second period.
2. Running 0x0400, write 0x3C00 (-1024) -> next period all low (DEAD), then CH_B high for 1024 clocks per period. Monitor converges to 0x3C00.
3. Write 0x2000 -> CH_B high for 8191 clocks, low for 1. Then write 0x1FFF -> one dead period, then CH_A high for 8191 clocks. The monitor reports 0x2001 and 0x1FFF respectively.
4. Write 0x0000 -> both outputs stay low. The monitor's timeout path yields duty=0x0000, and the next non-zero command of either sign enters RUN without a dead period.
5. Writes 0x0100 then 0x0200 in the same period -> duty_pend=1 until the boundary, only 0x0200 is applied. A write landing on the boundary edge applies in that same period, with duty_pend=0.
6. Assert rst mid-pulse at cnt=500 with mag=1024 -> CH_A=0 immediately, all state cleared. Separately, en=0 mid-period -> outputs low at the next edge, cnt=0; on en=1, prd_start pulses and the pulse train restarts with the retained duty.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared widths and FSM encoding for the sign/magnitude PWM generator.
package pwm_pkg;
   localparam int PERIOD_W = 13;
   localparam int DUTY_W   = PERIOD_W + 1;
   localparam logic [PERIOD_W-1:0] MAG_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } pwm_state_e;
endpackage

// File: rtl/pwm_mag_conv.sv
// Signed duty command to sign + magnitude; the most negative code saturates to full scale.
module pwm_mag_conv #(
   parameter int PERIOD_W = pwm_pkg::PERIOD_W,
   parameter int DUTY_W   = PERIOD_W + 1
) (
   input  logic [DUTY_W-1:0]   duty_i,
   output logic                sgn_o,
   output logic [PERIOD_W-1:0] mag_o
);
   logic [DUTY_W-1:0] abs_val;

   assign sgn_o   = duty_i[DUTY_W-1];
   assign abs_val = sgn_o ? (~duty_i + 1'b1) : duty_i;
   // Only -2^PERIOD_W still has the top bit set after negation.
   assign mag_o   = abs_val[DUTY_W-1] ? '1 : abs_val[PERIOD_W-1:0];
endmodule

// File: rtl/pwm_gen.sv
// Dual-channel sign/magnitude PWM: fixed 2^PERIOD_W period, shadowed duty applied at period
// boundaries, one all-low dead period inserted on direction reversal.
module pwm_gen #(
   parameter int PERIOD_W = pwm_pkg::PERIOD_W,
   parameter int DUTY_W   = PERIOD_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DUTY_W-1:0] duty,
   input  logic              duty_wr,
   output logic              CH_A,
   output logic              CH_B,
   output logic              prd_start,
   output logic              duty_pend
);
   import pwm_pkg::*;

   localparam logic [PERIOD_W-1:0] CNT_LAST = '1;

   pwm_state_e          state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] mag_q, mag_d;
   logic                sgn_q, sgn_d;
   logic [DUTY_W-1:0]   shadow_q, shadow_d;
   logic                pend_q, pend_d;
   logic                last_sgn_q, last_sgn_d;
   logic                last_nz_q, last_nz_d;
   logic                ch_a_q, ch_a_d;
   logic                ch_b_q, ch_b_d;
   logic                prd_q, prd_d;
   logic                load;

   logic                in_sgn, sh_sgn;
   logic [PERIOD_W-1:0] in_mag, sh_mag;

   pwm_mag_conv #(.PERIOD_W(PERIOD_W), .DUTY_W(DUTY_W)) u_conv_in (
      .duty_i (duty),
      .sgn_o  (in_sgn),
      .mag_o  (in_mag)
   );

   pwm_mag_conv #(.PERIOD_W(PERIOD_W), .DUTY_W(DUTY_W)) u_conv_sh (
      .duty_i (shadow_q),
      .sgn_o  (sh_sgn),
      .mag_o  (sh_mag)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mag_d      = mag_q;
      sgn_d      = sgn_q;
      shadow_d   = shadow_q;
      pend_d     = pend_q;
      last_sgn_d = last_sgn_q;
      last_nz_d  = last_nz_q;
      load       = 1'b0;

      if (duty_wr) begin
         shadow_d = duty;
         pend_d   = 1'b1;
      end

      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               load  = 1'b1;
               if (pend_q) begin
                  mag_d  = sh_mag;
                  sgn_d  = sh_sgn;
                  pend_d = duty_wr;
               end
            end
            RUN: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  load   = 1'b1;
                  pend_d = 1'b0;
                  if (duty_wr) begin
                     mag_d = in_mag;
                     sgn_d = in_sgn;
                  end else if (pend_q) begin
                     mag_d = sh_mag;
                     sgn_d = sh_sgn;
                  end
               end
            end
            DEAD: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST)
                  state_d = RUN;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase

         // A zero command clears the direction history: the line has already idled.
         if (load) begin
            state_d   = ((mag_d != '0) && last_nz_q && (sgn_d != last_sgn_q)) ? DEAD : RUN;
            last_nz_d = (mag_d != '0);
            if (mag_d != '0)
               last_sgn_d = sgn_d;
         end
      end

      ch_a_d = (state_d == RUN) & ~sgn_d & (cnt_d < mag_d);
      ch_b_d = (state_d == RUN) &  sgn_d & (cnt_d < mag_d);
      prd_d  = (state_d != IDLE) & (cnt_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mag_q      <= '0;
         sgn_q      <= 1'b0;
         shadow_q   <= '0;
         pend_q     <= 1'b0;
         last_sgn_q <= 1'b0;
         last_nz_q  <= 1'b0;
         ch_a_q     <= 1'b0;
         ch_b_q     <= 1'b0;
         prd_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mag_q      <= mag_d;
         sgn_q      <= sgn_d;
         shadow_q   <= shadow_d;
         pend_q     <= pend_d;
         last_sgn_q <= last_sgn_d;
         last_nz_q  <= last_nz_d;
         ch_a_q     <= ch_a_d;
         ch_b_q     <= ch_b_d;
         prd_q      <= prd_d;
      end
   end

   assign CH_A      = ch_a_q;
   assign CH_B      = ch_b_q;
   assign prd_start = prd_q;
   assign duty_pend = pend_q;
endmodule
